// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the CPU instruction-fetch and data channels.
// One outstanding transaction at a time; fixed-priority or round-robin on conflict.
module mem_bus_arbiter #(
    parameter int RR_EN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic        bus_ren,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_req_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rdata_valid,
    output logic        bus_rdata_ready,
    output logic [31:0] inst_grant_cnt,
    output logic [31:0] data_grant_cnt,
    output logic [31:0] conflict_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INST_REQ  = 3'd1,
        INST_RESP = 3'd2,
        DATA_REQ  = 3'd3,
        DATA_RESP = 3'd4
    } state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_t state_r;
    state_t next_state_s;
    logic   last_grant_r;
    logic   inst_req_s;
    logic   data_req_s;
    logic   conflict_s;
    logic   inst_acc_s;
    logic   data_acc_s;

    assign inst_req_s = Inst_Req_Valid;
    assign data_req_s = MemRead | MemWrite;
    assign conflict_s = (state_r == IDLE) && inst_req_s && data_req_s;
    assign inst_acc_s = (state_r == INST_REQ) && bus_req_ready;
    assign data_acc_s = (state_r == DATA_REQ) && bus_req_ready;

    // Next-state selection and steering of the owning channel onto the bus
    always_comb begin
        next_state_s    = state_r;
        Inst_Req_Ready  = 1'b0;
        Instruction     = 32'd0;
        Inst_Valid      = 1'b0;
        Mem_Req_Ready   = 1'b0;
        Read_data       = 32'd0;
        Read_data_Valid = 1'b0;
        bus_addr        = 32'd0;
        bus_wen         = 1'b0;
        bus_ren         = 1'b0;
        bus_wdata       = 32'd0;
        bus_strb        = 4'd0;
        bus_rdata_ready = 1'b0;
        case (state_r)
            IDLE: begin
                if (inst_req_s && data_req_s) begin
                    if ((RR_EN != 0) && (last_grant_r == GRANT_DATA)) begin
                        next_state_s = INST_REQ;
                    end else begin
                        next_state_s = DATA_REQ;
                    end
                end else if (data_req_s) begin
                    next_state_s = DATA_REQ;
                end else if (inst_req_s) begin
                    next_state_s = INST_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            INST_REQ: begin
                bus_ren        = 1'b1;
                bus_addr       = PC;
                Inst_Req_Ready = bus_req_ready;
                if (bus_req_ready) begin
                    next_state_s = INST_RESP;
                end else begin
                    next_state_s = INST_REQ;
                end
            end
            INST_RESP: begin
                Instruction     = bus_rdata;
                Inst_Valid      = bus_rdata_valid;
                bus_rdata_ready = Inst_Ready;
                if (bus_rdata_valid && Inst_Ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = INST_RESP;
                end
            end
            DATA_REQ: begin
                // Read and write together is a write: no read strobe, no response phase
                bus_addr      = Address;
                bus_wen       = MemWrite;
                bus_ren       = MemRead & ~MemWrite;
                bus_wdata     = Write_data;
                bus_strb      = Write_strb;
                Mem_Req_Ready = bus_req_ready;
                if (bus_req_ready) begin
                    if (MemWrite) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = DATA_RESP;
                    end
                end else begin
                    next_state_s = DATA_REQ;
                end
            end
            DATA_RESP: begin
                Read_data       = bus_rdata;
                Read_data_Valid = bus_rdata_valid;
                bus_rdata_ready = Read_data_Ready;
                if (bus_rdata_valid && Read_data_Ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DATA_RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state and the requester most recently granted the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_INST;
        end else begin
            state_r <= next_state_s;
            if (inst_acc_s) begin
                last_grant_r <= GRANT_INST;
            end else if (data_acc_s) begin
                last_grant_r <= GRANT_DATA;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Free-running perf counters; they wrap naturally at 32 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_grant_cnt <= 32'd0;
            data_grant_cnt <= 32'd0;
            conflict_cnt   <= 32'd0;
        end else begin
            if (inst_acc_s) begin
                inst_grant_cnt <= inst_grant_cnt + 32'd1;
            end else begin
                inst_grant_cnt <= inst_grant_cnt;
            end
            if (data_acc_s) begin
                data_grant_cnt <= data_grant_cnt + 32'd1;
            end else begin
                data_grant_cnt <= data_grant_cnt;
            end
            if (conflict_s) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end else begin
                conflict_cnt <= conflict_cnt;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: instance 0 fixed priority, instance 1 round robin.
module tb_mem_bus_arbiter;

    localparam logic [2:0] EV_GI = 3'd0;
    localparam logic [2:0] EV_GD = 3'd1;
    localparam logic [2:0] EV_GW = 3'd2;
    localparam logic [2:0] EV_RI = 3'd3;
    localparam logic [2:0] EV_RD = 3'd4;

    typedef struct packed {
        logic        dut;
        logic [2:0]  kind;
        logic [31:0] val;
        logic [31:0] aux;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0][31:0] pc;
    logic [1:0][31:0] address;
    logic [1:0][31:0] write_data;
    logic [1:0][3:0]  write_strb;
    logic [1:0]       inst_req_valid;
    logic [1:0]       inst_ready;
    logic [1:0]       mem_write;
    logic [1:0]       mem_read;
    logic [1:0]       read_data_ready;
    int               req_delay [2];

    wire [1:0]        inst_req_ready;
    wire [1:0]        inst_valid;
    wire [1:0]        mem_req_ready;
    wire [1:0]        read_data_valid;
    wire [1:0]        bus_wen;
    wire [1:0]        bus_ren;
    wire [1:0]        bus_rdata_ready;
    wire [1:0][31:0]  instruction;
    wire [1:0][31:0]  read_data;
    wire [1:0][31:0]  bus_addr;
    wire [1:0][31:0]  bus_wdata;
    wire [1:0][3:0]   bus_strb;
    wire [1:0][31:0]  inst_grant_cnt;
    wire [1:0][31:0]  data_grant_cnt;
    wire [1:0][31:0]  conflict_cnt;

    sb_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_2000: return 32'hCAFE_0001;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        bm_req_ready;
        logic        bm_rdata_valid;
        logic [31:0] bm_rdata;

        mem_bus_arbiter #(.RR_EN(g)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .PC              (pc[g]),
            .Inst_Req_Valid  (inst_req_valid[g]),
            .Inst_Req_Ready  (inst_req_ready[g]),
            .Instruction     (instruction[g]),
            .Inst_Valid      (inst_valid[g]),
            .Inst_Ready      (inst_ready[g]),
            .Address         (address[g]),
            .MemWrite        (mem_write[g]),
            .Write_data      (write_data[g]),
            .Write_strb      (write_strb[g]),
            .MemRead         (mem_read[g]),
            .Mem_Req_Ready   (mem_req_ready[g]),
            .Read_data       (read_data[g]),
            .Read_data_Valid (read_data_valid[g]),
            .Read_data_Ready (read_data_ready[g]),
            .bus_addr        (bus_addr[g]),
            .bus_wen         (bus_wen[g]),
            .bus_ren         (bus_ren[g]),
            .bus_wdata       (bus_wdata[g]),
            .bus_strb        (bus_strb[g]),
            .bus_req_ready   (bm_req_ready),
            .bus_rdata       (bm_rdata),
            .bus_rdata_valid (bm_rdata_valid),
            .bus_rdata_ready (bus_rdata_ready[g]),
            .inst_grant_cnt  (inst_grant_cnt[g]),
            .data_grant_cnt  (data_grant_cnt[g]),
            .conflict_cnt    (conflict_cnt[g])
        );

        // Bus slave: accepts after req_delay wait cycles, returns read data the cycle after accept
        initial begin : bus_model
            logic        acc;
            logic        rd_acc;
            logic        rsp_done;
            logic [31:0] acc_addr;
            int          wait_cnt;
            bm_req_ready   = 1'b0;
            bm_rdata_valid = 1'b0;
            bm_rdata       = 32'd0;
            wait_cnt       = 0;
            forever begin
                @(negedge clk);
                acc      = bm_req_ready & (bus_ren[g] | bus_wen[g]);
                rd_acc   = acc & bus_ren[g];
                acc_addr = bus_addr[g];
                rsp_done = bm_rdata_valid & bus_rdata_ready[g];
                @(posedge clk);
                #2;
                if (!rst) begin
                    bm_req_ready   = 1'b0;
                    bm_rdata_valid = 1'b0;
                    bm_rdata       = 32'd0;
                    wait_cnt       = 0;
                end else begin
                    if (rsp_done) begin
                        bm_rdata_valid = 1'b0;
                        bm_rdata       = 32'd0;
                    end
                    if (rd_acc) begin
                        bm_rdata_valid = 1'b1;
                        bm_rdata       = rdata_for(acc_addr);
                    end
                    if (acc) begin
                        bm_req_ready = 1'b0;
                        wait_cnt     = 0;
                    end
                    if ((bus_ren[g] | bus_wen[g]) && !bm_req_ready) begin
                        if (wait_cnt >= req_delay[g]) bm_req_ready = 1'b1;
                        else wait_cnt++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic d, input logic [2:0] k, input logic [31:0] v, input logic [31:0] a);
        sb_t e;
        e.dut  = d;
        e.kind = k;
        e.val  = v;
        e.aux  = a;
        exp_q.push_back(e);
    endtask

    task automatic sb_event(input logic d, input logic [2:0] k, input logic [31:0] v, input logic [31:0] a);
        sb_t want;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: dut=%0d kind=%0d val=0x%08h with nothing expected", d, k, v);
        end else begin
            want = exp_q.pop_front();
            if (want.dut !== d || want.kind !== k || want.val !== v || want.aux !== a) begin
                failures++;
                $display("FAIL sb_event: got dut=%0d kind=%0d val=0x%08h aux=0x%08h expected dut=%0d kind=%0d val=0x%08h aux=0x%08h",
                         d, k, v, a, want.dut, want.kind, want.val, want.aux);
            end
        end
    endtask

    // Monitor: every handshake the DUT completes at the next edge becomes one scoreboard event
    initial begin : monitor
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (inst_req_ready[d] && inst_req_valid[d])
                    sb_event(d[0], EV_GI, bus_addr[d], 32'd0);
                if (mem_req_ready[d] && (mem_read[d] || mem_write[d]))
                    sb_event(d[0], mem_write[d] ? EV_GW : EV_GD, bus_addr[d],
                             mem_write[d] ? bus_wdata[d] : 32'd0);
                if (inst_valid[d] && inst_ready[d])
                    sb_event(d[0], EV_RI, instruction[d], 32'd0);
                if (read_data_valid[d] && read_data_ready[d])
                    sb_event(d[0], EV_RD, read_data[d], 32'd0);
            end
        end
    end

    task automatic do_reset();
        rst             = 1'b0;
        pc              = '0;
        address         = '0;
        write_data      = '0;
        write_strb      = '0;
        inst_req_valid  = '0;
        inst_ready      = '0;
        mem_write       = '0;
        mem_read        = '0;
        read_data_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_grants(input int d, input logic [31:0] n_inst, input logic [31:0] n_data, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (inst_grant_cnt[d] == n_inst && data_grant_cnt[d] == n_data) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s: grant counters inst=%0d data=%0d never reached inst=%0d data=%0d",
                     name, inst_grant_cnt[d], data_grant_cnt[d], n_inst, n_data);
        end
    endtask

    task automatic check_outs_zero(input int d, input string name);
        check({name, "_ctl"}, 32'({inst_req_ready[d], inst_valid[d], mem_req_ready[d], read_data_valid[d],
                                   bus_wen[d], bus_ren[d], bus_rdata_ready[d]}), 32'd0);
        check({name, "_data"}, instruction[d] | read_data[d] | bus_addr[d] | bus_wdata[d] | 32'(bus_strb[d]), 32'd0);
    endtask

    task automatic check_counters(input int d, input logic [31:0] ei, input logic [31:0] ed,
                                  input logic [31:0] ec, input string name);
        check({name, "_inst_cnt"}, inst_grant_cnt[d], ei);
        check({name, "_data_cnt"}, data_grant_cnt[d], ed);
        check({name, "_conf_cnt"}, conflict_cnt[d], ec);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int wen_cycles;
        bit stable_ok;
        bit hit;
        req_delay[0] = 0;
        req_delay[1] = 0;

        // Reset state of both instances
        do_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_outs_zero(d, "reset");
            check_counters(d, 32'd0, 32'd0, 32'd0, "reset");
        end

        // Fetch only
        do_reset();
        pc[0] = 32'h0000_0100;
        inst_ready[0] = 1'b1;
        inst_req_valid[0] = 1'b1;
        expect_ev(1'b0, EV_GI, 32'h0000_0100, 32'd0);
        expect_ev(1'b0, EV_RI, 32'h0000_0013, 32'd0);
        wait_grants(0, 32'd1, 32'd0, "fetch_grant");
        inst_req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_counters(0, 32'd1, 32'd0, 32'd0, "fetch");
        check("fetch_sb_drained", 32'(exp_q.size()), 32'd0);

        // Fixed priority: simultaneous fetch and load, load first
        do_reset();
        pc[0] = 32'h0000_0100;
        address[0] = 32'h0000_2000;
        inst_ready[0] = 1'b1;
        read_data_ready[0] = 1'b1;
        inst_req_valid[0] = 1'b1;
        mem_read[0] = 1'b1;
        expect_ev(1'b0, EV_GD, 32'h0000_2000, 32'd0);
        expect_ev(1'b0, EV_RD, 32'hCAFE_0001, 32'd0);
        expect_ev(1'b0, EV_GI, 32'h0000_0100, 32'd0);
        expect_ev(1'b0, EV_RI, 32'h0000_0013, 32'd0);
        wait_grants(0, 32'd0, 32'd1, "fp_data_first");
        mem_read[0] = 1'b0;
        wait_grants(0, 32'd1, 32'd1, "fp_inst_second");
        inst_req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_counters(0, 32'd1, 32'd1, 32'd1, "fp");

        // Round robin with both requesters held: DATA, INST, DATA, INST
        do_reset();
        pc[1] = 32'h0000_0100;
        address[1] = 32'h0000_2000;
        inst_ready[1] = 1'b1;
        read_data_ready[1] = 1'b1;
        inst_req_valid[1] = 1'b1;
        mem_read[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_ev(1'b1, EV_GD, 32'h0000_2000, 32'd0);
            expect_ev(1'b1, EV_RD, 32'hCAFE_0001, 32'd0);
            expect_ev(1'b1, EV_GI, 32'h0000_0100, 32'd0);
            expect_ev(1'b1, EV_RI, 32'h0000_0013, 32'd0);
        end
        wait_grants(1, 32'd2, 32'd2, "rr_four_grants");
        inst_req_valid[1] = 1'b0;
        mem_read[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_counters(1, 32'd2, 32'd2, 32'd4, "rr");
        check("rr_sb_drained", 32'(exp_q.size()), 32'd0);

        // Store with a slow bus: three request cycles, no response phase
        do_reset();
        req_delay[0] = 2;
        read_data_ready[0] = 1'b1;
        address[0] = 32'h0000_0040;
        write_data[0] = 32'hDEAD_BEEF;
        write_strb[0] = 4'hF;
        mem_write[0] = 1'b1;
        expect_ev(1'b0, EV_GW, 32'h0000_0040, 32'hDEAD_BEEF);
        wen_cycles = 0;
        stable_ok = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (bus_wen[0]) begin
                wen_cycles++;
                if (bus_addr[0] != 32'h0000_0040 || bus_wdata[0] != 32'hDEAD_BEEF ||
                    bus_strb[0] != 4'hF || bus_ren[0]) stable_ok = 1'b0;
            end
            if (mem_req_ready[0]) hit = 1'b1;
        end
        check("st_accept_cycle", 32'(wen_cycles), 32'd3);
        check("st_payload_stable", 32'(stable_ok), 32'd1);
        @(posedge clk);
        #1 mem_write[0] = 1'b0;
        @(negedge clk);
        check("st_no_resp", 32'({bus_wen[0], bus_ren[0], bus_rdata_ready[0], mem_req_ready[0]}), 32'd0);
        check_counters(0, 32'd0, 32'd1, 32'd0, "st");
        req_delay[0] = 0;

        // Response back-pressure from the fetch side
        do_reset();
        pc[0] = 32'h0000_0100;
        inst_ready[0] = 1'b0;
        inst_req_valid[0] = 1'b1;
        expect_ev(1'b0, EV_GI, 32'h0000_0100, 32'd0);
        expect_ev(1'b0, EV_RI, 32'h0000_0013, 32'd0);
        wait_grants(0, 32'd1, 32'd0, "bp_grant");
        inst_req_valid[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({inst_valid[0], bus_rdata_ready[0]}), 32'd2);
            check("bp_word", instruction[0], 32'h0000_0013);
        end
        @(posedge clk);
        #1 inst_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(bus_rdata_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_done", 32'(inst_valid[0]), 32'd0);
        check("bp_sb_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a load sits in its response phase
        do_reset();
        address[0] = 32'h0000_2000;
        read_data_ready[0] = 1'b0;
        mem_read[0] = 1'b1;
        expect_ev(1'b0, EV_GD, 32'h0000_2000, 32'd0);
        wait_grants(0, 32'd0, 32'd1, "rstx_grant");
        mem_read[0] = 1'b0;
        @(negedge clk);
        check("rstx_in_resp", 32'(read_data_valid[0]), 32'd1);
        check("rstx_resp_data", read_data[0], 32'hCAFE_0001);
        #2 rst = 1'b0;
        #1;
        check_outs_zero(0, "rstx_async");
        check_counters(0, 32'd0, 32'd0, 32'd0, "rstx_async");
        read_data_ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outs_zero(0, "rstx_after");
        check_counters(0, 32'd0, 32'd0, 32'd0, "rstx_after");

        check("final_sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus between the CPU's instruction-fetch channel and its data channel.
- Sits between custom_cpu and the memory/bus bridge. The CPU-side port names and handshakes match the CPU exactly, so the arbiter drops in transparently.
- Handles one outstanding transaction at a time, with a selectable arbitration policy.
- Exposes grant and conflict counters for the CPU perf-counter outputs.

Parameters:
- RR_EN, 0, arbitration policy. 0 = fixed priority, data wins. 1 = round robin on conflict.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- PC  in  32  instruction fetch address
- Inst_Req_Valid  in  1  fetch request
- Inst_Req_Ready  out  1  fetch request accepted
- Instruction  out  32  fetched word
- Inst_Valid  out  1  fetched word valid
- Inst_Ready  in  1  CPU accepts fetched word
- Address  in  32  data address
- MemWrite  in  1  data write request
- Write_data  in  32  store data
- Write_strb  in  4  byte strobes
- MemRead  in  1  data read request
- Mem_Req_Ready  out  1  data request accepted
- Read_data  out  32  load data
- Read_data_Valid  out  1  load data valid
- Read_data_Ready  in  1  CPU accepts load data
- bus_addr  out  32  shared bus address
- bus_wen  out  1  shared write request
- bus_ren  out  1  shared read request
- bus_wdata  out  32  shared write data
- bus_strb  out  4  shared strobes
- bus_req_ready  in  1  bus accepted request
- bus_rdata  in  32  bus read data
- bus_rdata_valid  in  1  bus read data valid
- bus_rdata_ready  out  1  arbiter accepts read data
- inst_grant_cnt  out  32  accepted fetch requests
- data_grant_cnt  out  32  accepted data requests
- conflict_cnt  out  32  IDLE cycles with both requesters pending

Behaviour:
- FSM states: IDLE, INST_REQ, INST_RESP, DATA_REQ, DATA_RESP. Reset state is IDLE.
- Reset: asynchronous assertion forces IDLE, counters = 0 and last_grant = INST. All outputs read 0 in IDLE.
- Reset mid-transaction abandons the transaction. Nothing is replayed.
- Requests: data_req = MemRead | MemWrite; inst_req = Inst_Req_Valid.
- IDLE arbitration (grant takes effect next cycle, one cycle of arbitration latency):
  - data_req only -> DATA_REQ.
  - inst_req only -> INST_REQ.
  - Both pending: RR_EN=0 -> DATA_REQ. RR_EN=1 -> the requester not equal to last_grant.
  - Neither -> stay in IDLE.
- INST_REQ:
  - Drives bus_ren=1, bus_wen=0, bus_addr=PC, bus_wdata=0, bus_strb=0.
  - Inst_Req_Ready = bus_req_ready.
  - On bus_req_ready: go to INST_RESP, inst_grant_cnt+1, last_grant=INST.
- INST_RESP:
  - Instruction = bus_rdata, Inst_Valid = bus_rdata_valid, bus_rdata_ready = Inst_Ready.
  - On bus_rdata_valid & Inst_Ready: go to IDLE.
- DATA_REQ:
  - Drives bus_addr=Address, bus_wen=MemWrite, bus_ren=MemRead & ~MemWrite, bus_wdata=Write_data, bus_strb=Write_strb.
  - Mem_Req_Ready = bus_req_ready.
  - On handshake: data_grant_cnt+1, last_grant=DATA. Read -> DATA_RESP; write -> IDLE (writes have no response phase).
- DATA_RESP:
  - Read_data = bus_rdata, Read_data_Valid = bus_rdata_valid, bus_rdata_ready = Read_data_Ready.
  - On bus_rdata_valid & Read_data_Ready: go to IDLE.
- Output gating: every ready/valid/data output not owned by the current state is 0. The non-granted requester therefore sees ready=0 and stalls.
- Requesters must hold request and payload stable until accepted. The arbiter never re-arbitrates inside *_REQ.
- MemRead & MemWrite both set: treated as a write, so bus_ren=0 and there is no response phase.
- Counters: 32-bit, wrap 0xFFFFFFFF -> 0. conflict_cnt increments every IDLE cycle in which both requests are pending.
- Minimum round trips: 3 cycles per read (IDLE, REQ, RESP) with zero-wait bus; 2 cycles per write.

Test Plan:
- Reset while in DATA_RESP (rst low mid-cycle, no clock edge) -> all outputs 0 immediately; after release, FSM in IDLE and counters 0.
- Fetch only, PC=0x100, bus returns 0x00000013 one cycle after accept -> Inst_Req_Ready pulses once, Inst_Valid with Instruction=0x13; inst_grant_cnt=1.
- RR_EN=0, fetch and load (Address=0x2000) raised together -> load served first, then fetch; conflict_cnt=1; data_grant_cnt=1 before inst_grant_cnt=1.
- RR_EN=1, both requesters held continuously for 4 transactions, last_grant=INST at start -> grant order DATA, INST, DATA, INST.
- Store Address=0x40, Write_data=0xDEADBEEF, strb=0xF, bus_req_ready delayed 3 cycles -> bus_wen held 3 cycles with stable payload; Mem_Req_Ready high only in accept cycle; FSM returns to IDLE with no response phase.
- Back-pressure: bus_rdata_valid high while Inst_Ready=0 for 2 cycles -> FSM stays in INST_RESP, bus_rdata_ready=0; completes on the cycle Inst_Ready rises.
